// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver for the RISC5 I/O space.
// Slot 6 holds status/control and slot 7 holds data. Each good scan-code
// byte is written into a small FIFO. The FIFO is read through dout and
// monitored through status.
module ps2_kbd #(
    parameter int unsigned FIFO_LOG2 = 3,
    parameter int unsigned TIMEOUT   = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_en,
    input  logic        ctrl_en,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [31:0] status,
    input  logic        ps2_clk,
    input  logic        ps2_data
);

    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned CNT_W = FIFO_LOG2 + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Input conditioning
    logic [1:0] sync_clk;
    logic [1:0] sync_data;
    logic       clk_prev;
    logic       fe_c;
    logic       bit_c;

    // Receiver
    state_t            state;
    logic [2:0]        bitcnt;
    logic [7:0]        shreg;
    logic              parity;
    logic [TO_W-1:0]   to_cnt;
    logic              push;
    logic              perr_set;

    // FIFO and flags
    logic [7:0]           mem [DEPTH];
    logic [FIFO_LOG2-1:0] rdptr;
    logic [FIFO_LOG2-1:0] wrptr;
    logic [CNT_W-1:0]     count;
    logic                 perr;
    logic                 ovr;

    logic empty_c;
    logic full_c;
    logic pop_c;
    logic flush_c;
    logic clr_c;
    logic wr_ok_c;
    logic ovr_set_c;
    logic unused_din_c;

    // Two-flop synchronisers plus the previous clock level for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_clk  <= 2'b11;
            sync_data <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            sync_clk  <= {sync_clk[0], ps2_clk};
            sync_data <= {sync_data[0], ps2_data};
            clk_prev  <= sync_clk[1];
        end
    end

    assign fe_c  = clk_prev & ~sync_clk[1];
    assign bit_c = sync_data[1];

    // Frame receiver FSM with an inactivity timeout that abandons partial frames
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bitcnt   <= 3'd0;
            shreg    <= 8'd0;
            parity   <= 1'b0;
            to_cnt   <= '0;
            push     <= 1'b0;
            perr_set <= 1'b0;
        end else begin
            push     <= 1'b0;
            perr_set <= 1'b0;
            if (fe_c) begin
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!bit_c) begin
                            state  <= DATA;
                            bitcnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shreg  <= {bit_c, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity <= bit_c;
                        state  <= STOP;
                    end
                    STOP: begin
                        if (bit_c && (^{shreg, parity})) begin
                            push <= 1'b1;
                        end else begin
                            perr_set <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    state  <= IDLE;
                    bitcnt <= 3'd0;
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    assign empty_c   = (count == '0);
    assign full_c    = (count == CNT_W'(DEPTH));
    assign pop_c     = data_en & rd & ~empty_c;
    assign flush_c   = ctrl_en & wr & din[0];
    assign clr_c     = ctrl_en & wr & din[1];
    assign wr_ok_c   = push & ~flush_c & (~full_c | pop_c);
    assign ovr_set_c = push & ~flush_c & full_c & ~pop_c;

    assign unused_din_c = ^din[31:2];

    // FIFO storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[wrptr] <= shreg;
        end
    end

    // FIFO pointers and occupancy; a flush overrides any push or pop in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdptr <= '0;
            wrptr <= '0;
            count <= '0;
        end else if (flush_c) begin
            rdptr <= '0;
            wrptr <= '0;
            count <= '0;
        end else begin
            if (wr_ok_c) begin
                wrptr <= wrptr + 1'b1;
            end
            if (pop_c) begin
                rdptr <= rdptr + 1'b1;
            end
            case ({wr_ok_c, pop_c})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as a clear takes priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perr <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            perr <= perr_set  | (perr & ~clr_c);
            ovr  <= ovr_set_c | (ovr  & ~clr_c);
        end
    end

    // Read-side views for the I/O multiplexer
    assign dout   = empty_c ? 32'h0 : {24'h0, mem[rdptr]};
    assign status = 32'({count, 4'b0000, ovr, perr, full_c, ~empty_c});

endmodule

// File: tb/tb_ps2_kbd.sv
// Directed bench for ps2_kbd: PS/2 frames are built bit by bit, and the
// FIFO and status behaviour is checked against hand-computed values.
module tb_ps2_kbd;

    localparam int unsigned TO   = 200;
    localparam int unsigned HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_en = 1'b0;
    logic        ctrl_en = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] din = 32'h0;
    logic [31:0] dout;
    logic [31:0] status;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] pop_seen;
    logic [31:0] v;

    ps2_kbd #(.FIFO_LOG2(3), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .data_en(data_en), .ctrl_en(ctrl_en),
        .rd(rd), .wr(wr), .din(din), .dout(dout), .status(status),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit; optionally pops the FIFO in the cycle the byte is pushed
    task automatic ps2_bit(input logic b, input logic pop_here);
        ps2_data = b;
        step(HALF);
        ps2_clk = 1'b0;
        if (pop_here) begin
            step(3);
            data_en  = 1'b1;
            rd       = 1'b1;
            pop_seen = dout;
            step(1);
            data_en  = 1'b0;
            rd       = 1'b0;
            step(HALF - 4);
        end else begin
            step(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic pop_stop);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit((~^b) ^ bad_par, 1'b0);
        ps2_bit(1'b1, pop_stop);
        step(6);
    endtask

    task automatic send_partial(input int nbits);
        ps2_bit(1'b0, 1'b0);
        for (int i = 1; i < nbits; i++) ps2_bit(1'b1, 1'b0);
    endtask

    task automatic read_data(output logic [31:0] val);
        data_en = 1'b1;
        rd      = 1'b1;
        val     = dout;
        step(1);
        data_en = 1'b0;
        rd      = 1'b0;
        step(1);
    endtask

    task automatic ctrl_write(input logic [31:0] d);
        ctrl_en = 1'b1;
        wr      = 1'b1;
        din     = d;
        step(1);
        ctrl_en = 1'b0;
        wr      = 1'b0;
        din     = 32'h0;
        step(1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);
        n_total++;
        if (status !== 32'h0) $display("FAIL reset_status got=%h exp=%h", status, 32'h0);
        else n_pass++;
        n_total++;
        if (dout !== 32'h0) $display("FAIL reset_dout got=%h exp=%h", dout, 32'h0);
        else n_pass++;
    endtask

    task automatic test_single;
        send_frame(8'h1C, 1'b0, 1'b0);
        n_total++;
        if (status !== 32'h101) $display("FAIL single_status got=%h exp=%h", status, 32'h101);
        else n_pass++;
        read_data(v);
        n_total++;
        if (v !== 32'h1C) $display("FAIL single_dout got=%h exp=%h", v, 32'h1C);
        else n_pass++;
        n_total++;
        if (status !== 32'h0) $display("FAIL single_empty got=%h exp=%h", status, 32'h0);
        else n_pass++;
        read_data(v);
        n_total++;
        if (v !== 32'h0) $display("FAIL empty_read got=%h exp=%h", v, 32'h0);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        n_total++;
        if (status !== 32'h201) $display("FAIL b2b_status got=%h exp=%h", status, 32'h201);
        else n_pass++;
        read_data(v);
        n_total++;
        if (v !== 32'hF0) $display("FAIL b2b_first got=%h exp=%h", v, 32'hF0);
        else n_pass++;
        read_data(v);
        n_total++;
        if (v !== 32'h1C) $display("FAIL b2b_second got=%h exp=%h", v, 32'h1C);
        else n_pass++;
        n_total++;
        if (status !== 32'h0) $display("FAIL b2b_empty got=%h exp=%h", status, 32'h0);
        else n_pass++;
    endtask

    task automatic test_parity_error;
        send_frame(8'h1C, 1'b1, 1'b0);
        n_total++;
        if (status !== 32'h004) $display("FAIL perr_status got=%h exp=%h", status, 32'h004);
        else n_pass++;
        ctrl_write(32'h2);
        n_total++;
        if (status !== 32'h0) $display("FAIL perr_clear got=%h exp=%h", status, 32'h0);
        else n_pass++;
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        n_total++;
        if (status !== 32'h80B) $display("FAIL ovr_status got=%h exp=%h", status, 32'h80B);
        else n_pass++;
        data_en = 1'b1;
        wr      = 1'b1;
        din     = 32'h3;
        step(1);
        data_en = 1'b0;
        wr      = 1'b0;
        din     = 32'h0;
        step(1);
        n_total++;
        if (status !== 32'h80B) $display("FAIL data_write_ignored got=%h exp=%h", status, 32'h80B);
        else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            read_data(v);
            n_total++;
            if (v !== 32'(i)) $display("FAIL ovr_read%0d got=%h exp=%h", i, v, 32'(i));
            else n_pass++;
        end
        n_total++;
        if (status !== 32'h008) $display("FAIL ovr_drained got=%h exp=%h", status, 32'h008);
        else n_pass++;
        ctrl_write(32'h2);
        n_total++;
        if (status !== 32'h0) $display("FAIL ovr_clear got=%h exp=%h", status, 32'h0);
        else n_pass++;
    endtask

    task automatic test_full_pop;
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0);
        n_total++;
        if (status !== 32'h803) $display("FAIL full_status got=%h exp=%h", status, 32'h803);
        else n_pass++;
        send_frame(8'h09, 1'b0, 1'b1);
        n_total++;
        if (pop_seen !== 32'h01) $display("FAIL full_pop_dout got=%h exp=%h", pop_seen, 32'h01);
        else n_pass++;
        n_total++;
        if (status !== 32'h803) $display("FAIL full_pop_status got=%h exp=%h", status, 32'h803);
        else n_pass++;
        for (int i = 2; i <= 9; i++) begin
            read_data(v);
            n_total++;
            if (v !== 32'(i)) $display("FAIL full_pop_read%0d got=%h exp=%h", i, v, 32'(i));
            else n_pass++;
        end
        n_total++;
        if (status !== 32'h0) $display("FAIL full_pop_empty got=%h exp=%h", status, 32'h0);
        else n_pass++;
    endtask

    task automatic test_flush;
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0);
        ctrl_write(32'h1);
        n_total++;
        if (status !== 32'h0) $display("FAIL flush_status got=%h exp=%h", status, 32'h0);
        else n_pass++;
        n_total++;
        if (dout !== 32'h0) $display("FAIL flush_dout got=%h exp=%h", dout, 32'h0);
        else n_pass++;
    endtask

    task automatic test_timeout;
        send_partial(5);
        step(TO + 20);
        send_frame(8'h1C, 1'b0, 1'b0);
        n_total++;
        if (status !== 32'h101) $display("FAIL timeout_status got=%h exp=%h", status, 32'h101);
        else n_pass++;
        read_data(v);
        n_total++;
        if (v !== 32'h1C) $display("FAIL timeout_dout got=%h exp=%h", v, 32'h1C);
        else n_pass++;
        n_total++;
        if (status !== 32'h0) $display("FAIL timeout_empty got=%h exp=%h", status, 32'h0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        send_frame(8'h33, 1'b0, 1'b0);
        send_partial(5);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        n_total++;
        if (status !== 32'h0) $display("FAIL midrst_status got=%h exp=%h", status, 32'h0);
        else n_pass++;
        send_frame(8'h1C, 1'b0, 1'b0);
        n_total++;
        if (status !== 32'h101) $display("FAIL midrst_after got=%h exp=%h", status, 32'h101);
        else n_pass++;
        read_data(v);
        n_total++;
        if (v !== 32'h1C) $display("FAIL midrst_dout got=%h exp=%h", v, 32'h1C);
        else n_pass++;
    endtask

    initial begin
        pop_seen = 32'h0;
        v        = 32'h0;
        test_reset;
        test_single;
        test_back_to_back;
        test_parity_error;
        test_overflow;
        test_full_pop;
        test_flush;
        test_timeout;
        test_reset_mid_frame;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
